// File: rtl/lock_entry_sequencer_if.sv
// Keypad/control handshake between the lock front end and the entry sequencer.
interface lock_entry_sequencer_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       prog_en;
  logic       relock;
  logic       unlocked;
  logic       alarm;
  logic [1:0] fail_cnt;
  logic [2:0] state_o;

  modport master (
    output key_valid, key_digit, prog_en, relock,
    input  unlocked, alarm, fail_cnt, state_o
  );
  modport slave (
    input  key_valid, key_digit, prog_en, relock,
    output unlocked, alarm, fail_cnt, state_o
  );
endinterface

// File: rtl/lock_entry_sequencer.sv
// Combination-lock sequencer: digit collection, code compare, failure lockout,
// code re-programming while open, and idle timeouts.
module lock_entry_sequencer #(
  parameter int                      CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE   = 16'h1234,
  parameter int                      MAX_FAILS      = 3,
  parameter int                      LOCKOUT_CYCLES = 16,
  parameter int                      ENTRY_TIMEOUT  = 32,
  parameter int                      UNLOCK_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lock_entry_sequencer_if.slave   bus
);
  localparam int BW   = 4 * CODE_LEN;
  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam int TMAX = (LOCKOUT_CYCLES > ENTRY_TIMEOUT)
                        ? ((LOCKOUT_CYCLES > UNLOCK_TIMEOUT) ? LOCKOUT_CYCLES : UNLOCK_TIMEOUT)
                        : ((ENTRY_TIMEOUT  > UNLOCK_TIMEOUT) ? ENTRY_TIMEOUT  : UNLOCK_TIMEOUT);
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_PROGRAM = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [BW-1:0]   code_q, code_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [1:0]      fail_q, fail_d;
  logic            unlocked_q, unlocked_d;
  logic            alarm_q, alarm_d;

  logic            tmr_clr;
  logic            entry_to;
  logic            last_digit;
  logic [BW-1:0]   shifted;
  logic [2:0]      fail_inc;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    tmr_clr  = 1'b0;

    entry_to   = (tmr_q >= TW'(ENTRY_TIMEOUT - 1));
    last_digit = (cnt_q == CW'(CODE_LEN - 1));
    shifted    = (buf_q << 4) | BW'(bus.key_digit);
    fail_inc   = {1'b0, fail_q} + 3'd1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.key_valid) begin
          buf_d   = BW'(bus.key_digit);
          cnt_d   = CW'(1);
          state_d = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
        end
      end
      S_ENTRY: begin
        // Timeout has priority over a simultaneous digit, which is dropped.
        if (bus.relock || entry_to) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (bus.key_valid) begin
          buf_d   = shifted;
          cnt_d   = cnt_q + CW'(1);
          tmr_clr = 1'b1;
          if (last_digit) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (buf_q == code_q) begin
          fail_d  = '0;
          state_d = S_OPEN;
        end else if (fail_inc < 3'(MAX_FAILS)) begin
          fail_d  = fail_inc[1:0];
          state_d = S_IDLE;
        end else begin
          fail_d  = 2'(MAX_FAILS);
          state_d = S_LOCKOUT;
        end
      end
      S_OPEN: begin
        if (bus.relock) begin
          state_d = S_IDLE;
        end else if (bus.prog_en) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_PROGRAM;
        end else if (tmr_q >= TW'(UNLOCK_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_PROGRAM: begin
        if (bus.relock || !bus.prog_en || entry_to) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = bus.relock ? S_IDLE : S_OPEN;
        end else if (bus.key_valid) begin
          buf_d   = shifted;
          cnt_d   = cnt_q + CW'(1);
          tmr_clr = 1'b1;
          if (last_digit) begin
            code_d  = shifted;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_OPEN;
          end
        end
      end
      S_LOCKOUT: begin
        if (tmr_q >= TW'(LOCKOUT_CYCLES - 1)) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // One shared timer: every state change restarts it, digits restart it too.
    if (state_d != state_q || tmr_clr) tmr_d = '0;
    else if (tmr_q == TW'(TMAX))       tmr_d = tmr_q;
    else                               tmr_d = tmr_q + TW'(1);

    unlocked_d = (state_d == S_OPEN) || (state_d == S_PROGRAM);
    alarm_d    = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      code_q     <= DEFAULT_CODE;
      cnt_q      <= '0;
      tmr_q      <= '0;
      fail_q     <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
    end
  end

  assign bus.unlocked = unlocked_q;
  assign bus.alarm    = alarm_q;
  assign bus.fail_cnt = fail_q;
  assign bus.state_o  = state_q;
endmodule

// File: tb/tb_lock_entry_sequencer.sv
// Directed bench for lock_entry_sequencer with a reference code/fail model and expectation queue.
module tb_lock_entry_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lock_entry_sequencer_if bus();
  lock_entry_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       u;
    logic       a;
    logic [1:0] f;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] model_code  = 16'h1234;
  int          model_fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [2:0] st, input logic u,
                          input logic a, input logic [1:0] f);
    exp_t e;
    e.tag = tag; e.st = st; e.u = u; e.a = a; e.f = f;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: no expectation queued");
    end else begin
      e = sb.pop_front();
      assert ({bus.state_o, bus.unlocked, bus.alarm, bus.fail_cnt} === {e.st, e.u, e.a, e.f})
      else begin
        bad++;
        $error("FAIL %s: got st=%0d unl=%0b alm=%0b fc=%0d, want st=%0d unl=%0b alm=%0b fc=%0d",
               e.tag, bus.state_o, bus.unlocked, bus.alarm, bus.fail_cnt,
               e.st, e.u, e.a, e.f);
      end
    end
  endtask

  task automatic exp_now(input string tag, input logic [2:0] st, input logic u, input logic a);
    push_exp(tag, st, u, a, 2'(model_fails));
    check_out();
  endtask

  task automatic strobe(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    tick();
    bus.key_valid = 1'b0;
  endtask

  // Enter a full code from IDLE; check the CHECK cycle and the outcome.
  task automatic enter_code(input string tag, input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      strobe(code[15-4*i -: 4]);
      if (i < 3) repeat (2) tick();
    end
    push_exp({tag, "_check"}, 3'd2, 1'b0, 1'b0, 2'(model_fails));
    if (code == model_code) begin
      model_fails = 0;
      push_exp(tag, 3'd3, 1'b1, 1'b0, 2'd0);
    end else if (model_fails + 1 < 3) begin
      model_fails++;
      push_exp(tag, 3'd0, 1'b0, 1'b0, 2'(model_fails));
    end else begin
      model_fails = 3;
      push_exp(tag, 3'd5, 1'b0, 1'b1, 2'd3);
    end
    check_out();
    tick();
    check_out();
  endtask

  // Program a new code while in PROGRAM with prog_en held high.
  task automatic prog_code(input string tag, input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      strobe(code[15-4*i -: 4]);
      if (i < 3) begin
        exp_now({tag, "_mid"}, 3'd4, 1'b1, 1'b0);
        repeat (2) tick();
      end
    end
    model_code = code;
    exp_now(tag, 3'd3, 1'b1, 1'b0);
  endtask

  task automatic pulse_relock(input string tag);
    bus.relock = 1'b1;
    tick();
    bus.relock = 1'b0;
    exp_now(tag, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.prog_en = 1'b0;
    model_fails = 0;
    model_code  = 16'h1234;
    exp_now(tag, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.prog_en   = 1'b0;
    bus.relock    = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_now("reset", 3'd0, 1'b0, 1'b0);

    // Correct code opens, relock closes
    enter_code("open1234", 16'h1234);
    pulse_relock("relock1");

    // Three wrong codes -> lockout; inputs ignored during lockout
    enter_code("wrong1", 16'h1235);
    enter_code("wrong2", 16'h1235);
    enter_code("wrong3", 16'h1235);
    for (int i = 0; i < 15; i++) begin
      bus.key_valid = (i < 8) && (i % 2 == 0);
      bus.key_digit = 4'(i / 2 + 1);
      bus.relock    = (i == 9);
      bus.prog_en   = (i == 11);
      tick();
    end
    bus.key_valid = 1'b0; bus.relock = 1'b0; bus.prog_en = 1'b0;
    exp_now("lockout_hold", 3'd5, 1'b0, 1'b1);
    tick();
    model_fails = 0;
    exp_now("lockout_end", 3'd0, 1'b0, 1'b0);

    // One wrong then correct clears fail count
    enter_code("wrong_once", 16'h1235);
    enter_code("open_after_fail", 16'h1234);

    // Program 9876 while open
    bus.prog_en = 1'b1;
    tick();
    exp_now("enter_prog", 3'd4, 1'b1, 1'b0);
    prog_code("prog9876", 16'h9876);
    bus.prog_en = 1'b0;
    pulse_relock("relock_prog");
    enter_code("old_code_fails", 16'h1234);
    enter_code("new_code_opens", 16'h9876);

    // Reset in the middle of PROGRAM restores the default code
    bus.prog_en = 1'b1;
    tick();
    exp_now("prog_again", 3'd4, 1'b1, 1'b0);
    strobe(4'd5);
    do_reset("reset_mid_prog");
    enter_code("default_after_rst", 16'h1234);

    // Partial program aborted by dropping prog_en
    bus.prog_en = 1'b1;
    tick();
    exp_now("prog_partial", 3'd4, 1'b1, 1'b0);
    strobe(4'd5);
    repeat (2) tick();
    strobe(4'd5);
    repeat (2) tick();
    bus.prog_en = 1'b0;
    tick();
    exp_now("prog_abort", 3'd3, 1'b1, 1'b0);
    pulse_relock("relock_abort");
    enter_code("code_unchanged", 16'h1234);
    pulse_relock("relock_unch");

    // Entry timeout discards a partial entry without counting a failure
    enter_code("wrong_pre_to", 16'h1235);
    strobe(4'd1);
    repeat (2) tick();
    strobe(4'd2);
    repeat (31) tick();
    exp_now("entry_before_to", 3'd1, 1'b0, 1'b0);
    tick();
    exp_now("entry_timeout", 3'd0, 1'b0, 1'b0);

    // Auto-relock after the unlock timeout
    enter_code("open_for_auto", 16'h1234);
    repeat (63) tick();
    exp_now("open_before_to", 3'd3, 1'b1, 1'b0);
    tick();
    exp_now("auto_relock", 3'd0, 1'b0, 1'b0);

    // Reset in the middle of LOCKOUT
    enter_code("lk_w1", 16'h4321);
    enter_code("lk_w2", 16'h4321);
    enter_code("lk_w3", 16'h4321);
    repeat (5) tick();
    exp_now("lk_mid", 3'd5, 1'b0, 1'b1);
    do_reset("reset_mid_lockout");
    enter_code("open_after_lk_rst", 16'h1234);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: %0d expectations unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lock_entry_sequencer.md
Name: lock_entry_sequencer

Overview:
Sequencing controller for the FSM combination lock. It collects keypad digits, compares a full code against a programmable stored code, and drives the unlock output. It also counts failed attempts, enforces a timed alarm lockout after too many failures, and supports re-programming the code while open. It sits between the keypad front end (debounced one-cycle digit strobes) and the top-level lock outputs.

Parameters:
CODE_LEN, 4, number of digits per code (1..8)
DEFAULT_CODE, 16'h1234, reset code; width 4*CODE_LEN; first-entered digit is the MS nibble
MAX_FAILS, 3, consecutive wrong codes that trigger lockout (1..3)
LOCKOUT_CYCLES, 16, cycles spent in LOCKOUT
ENTRY_TIMEOUT, 32, idle cycles in ENTRY/PROGRAM before the partial entry is discarded
UNLOCK_TIMEOUT, 64, cycles in OPEN with no relock/prog activity before auto-relock

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
key_valid  in  1  one-cycle strobe; key_digit is valid this cycle
key_digit  in  4  digit value 0..15
prog_en  in  1  level; request code programming while open
relock  in  1  one-cycle pulse; force relock
unlocked  out  1  lock open (registered)
alarm  out  1  high during lockout (registered)
fail_cnt  out  2  consecutive failures so far
state_o  out  3  IDLE=0 ENTRY=1 CHECK=2 OPEN=3 PROGRAM=4 LOCKOUT=5

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n sampled on the clk rising edge). It overrides everything, including mid-entry, mid-program and mid-lockout.
- Reset values: state=IDLE, stored code=DEFAULT_CODE, entry buffer=0, digit count=0, timers=0, unlocked=0, alarm=0, fail_cnt=0.
- Entry buffer: shift-left by 4, new digit enters the LS nibble. After CODE_LEN digits the first digit is in the MS nibble.
- IDLE:
  - key_valid: load the digit, set count=1, go to ENTRY. If CODE_LEN==1, go straight to CHECK.
  - relock and prog_en are ignored.
- ENTRY:
  - Each key_valid shifts in a digit and clears the entry timer.
  - The strobe that completes CODE_LEN digits moves to CHECK.
  - Timer reaching ENTRY_TIMEOUT: discard the buffer, go to IDLE. This does not count as a failure.
  - relock in ENTRY: discard, go to IDLE.
- CHECK: exactly one cycle; key_valid is dropped.
  - Match: go to OPEN, clear fail_cnt.
  - Mismatch, fail_cnt+1 < MAX_FAILS: increment fail_cnt, go to IDLE.
  - Mismatch, fail_cnt+1 == MAX_FAILS: set fail_cnt=MAX_FAILS, go to LOCKOUT.
- Latency: last digit strobe at edge t gives CHECK at t+1. unlocked=1 (or alarm=1) is visible after edge t+2.
- OPEN:
  - unlocked=1. key_valid without prog_en is ignored. Unlock timer counts every cycle.
  - relock: go to IDLE, unlocked=0.
  - prog_en (without relock): go to PROGRAM; clear the buffer, count and entry timer.
  - relock and prog_en in the same cycle: relock wins.
  - Timer reaching UNLOCK_TIMEOUT: go to IDLE.
- PROGRAM:
  - unlocked stays 1. Digits are collected as in ENTRY.
  - The strobe completing CODE_LEN digits writes the stored code (including the new digit) and returns to OPEN with the unlock timer cleared.
  - prog_en low before completion: abort, stored code unchanged, return to OPEN.
  - relock: abort, go to IDLE.
  - Entry timeout: abort, return to OPEN.
- LOCKOUT:
  - alarm=1. key_valid, relock and prog_en are all ignored.
  - After exactly LOCKOUT_CYCLES cycles in LOCKOUT: go to IDLE, alarm=0, fail_cnt=0.
- Output decoding: unlocked = state in {OPEN, PROGRAM}; alarm = state==LOCKOUT. Both are registered with state, so there are no glitches.
- Counters: sized to the max of the timeout parameters, saturating, cleared on every state change.
- A key_valid arriving in the same cycle a timeout fires is dropped.

Test Plan:
- Reset, then enter 1,2,3,4 with gaps of 2 cycles: unlocked=1 two cycles after the 4th strobe, state_o=3, fail_cnt=0; relock pulse then gives unlocked=0, state_o=0.
- Enter 1,2,3,5 three times: fail_cnt reads 1, then 2; the third attempt gives alarm=1 and state_o=5. Strobing 1,2,3,4 during lockout has no effect. After 16 cycles: alarm=0, fail_cnt=0, state_o=0.
- Wrong code once (fail_cnt=1), then the correct code: unlocked=1, fail_cnt=0.
- Open the lock, raise prog_en, enter 9,8,7,6, drop prog_en, relock. Entering 1,2,3,4 must now fail (fail_cnt=1); entering 9,8,7,6 must unlock.
- Open the lock, prog_en high, enter 5,5, drop prog_en: state_o=3 and the code is still 1234. Enter 1,2 then idle 32 cycles: state_o=0, fail_cnt unchanged. Open the lock and wait 64 cycles: unlocked=0 (auto-relock).
- Assert rst_n=0 for one cycle mid-PROGRAM and mid-LOCKOUT: next cycle state_o=0, unlocked=0, alarm=0, code=1234.
